rv32_stall_scheduler: RTL

- Central stall/flush sequencer for the five-stage rv32 pipeline: fetch, decode, execute, mem, writeback.
- Consumes decode's unregistered hazard outputs (rs1/rs2 indices, read enables, fence flag) plus later-stage status.
- Drives per-stage stall and flush, and runs a multi-cycle FENCE/FENCE.I drain FSM that empties the pipeline and invalidates the I-cache.
- Keeps a free-running stall-cycle performance counter.

---
 rtl/rv32_stall_scheduler_pkg.sv | 36 +++
 rtl/rv32_load_use_detect.sv | 27 ++
 rtl/rv32_stall_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rv32_stall_scheduler_pkg.sv
// Shared types for the rv32 stall/flush sequencer: fence drain FSM states and
// the per-stage stall/flush control bundle.
package rv32_stall_scheduler_pkg;

  localparam int unsigned RegIdxW = 5;

  // Encodings are fixed so formal checks and waveforms can refer to them by value.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrain   = 2'd1,
    StInval   = 2'd2,
    StRelease = 2'd3
  } fence_state_e;

  typedef struct packed {
    logic fetch_stall;
    logic decode_stall;
    logic execute_stall;
    logic fetch_flush;
    logic decode_flush;
    logic execute_flush;
    logic mem_flush;
    logic writeback_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlNone = '0;

  // The pipeline behind decode holds nothing and the data bus is idle.
  function automatic logic pipe_drained(input logic ex_valid,
                                        input logic mem_valid,
                                        input logic wb_valid,
                                        input logic mem_wait);
    return !ex_valid && !mem_valid && !wb_valid && !mem_wait;
  endfunction

endpackage

// File: rtl/rv32_load_use_detect.sv
// Combinational load-use hazard detector: the instruction in decode reads the
// destination of a load still sitting in execute.
module rv32_load_use_detect
  import rv32_stall_scheduler_pkg::*;
(
  input  logic               decode_valid_i,
  input  logic [RegIdxW-1:0] rs1_i,
  input  logic               rs1_read_i,
  input  logic [RegIdxW-1:0] rs2_i,
  input  logic               rs2_read_i,
  input  logic               ex_valid_i,
  input  logic               ex_mem_read_i,
  input  logic [RegIdxW-1:0] ex_rd_i,
  output logic               load_use_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic load_in_ex;

  // x0 is never a real dependency.
  assign load_in_ex = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0);
  assign rs1_hit    = rs1_read_i && (rs1_i == ex_rd_i);
  assign rs2_hit    = rs2_read_i && (rs2_i == ex_rd_i);
  assign load_use_o = decode_valid_i && load_in_ex && (rs1_hit || rs2_hit);

endmodule

// File: rtl/rv32_stall_scheduler.sv
// Central stall/flush sequencer for the five-stage rv32 pipeline, including the
// FENCE/FENCE.I drain FSM and a stall-cycle performance counter.
module rv32_stall_scheduler
  import rv32_stall_scheduler_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 decode_valid_in,
  input  logic [RegIdxW-1:0]   rs1_in,
  input  logic                 rs1_read_in,
  input  logic [RegIdxW-1:0]   rs2_in,
  input  logic                 rs2_read_in,
  input  logic                 mem_fence_in,
  input  logic                 fence_i_in,
  input  logic                 ex_valid_in,
  input  logic                 ex_mem_read_in,
  input  logic [RegIdxW-1:0]   ex_rd_in,
  input  logic                 mem_valid_in,
  input  logic                 mem_wait_in,
  input  logic                 wb_valid_in,
  input  logic                 mispredict_in,
  input  logic                 trap_in,
  input  logic                 icache_flush_done_in,
  output logic                 fetch_stall_out,
  output logic                 decode_stall_out,
  output logic                 execute_stall_out,
  output logic                 fetch_flush_out,
  output logic                 decode_flush_out,
  output logic                 execute_flush_out,
  output logic                 mem_flush_out,
  output logic                 writeback_flush_out,
  output logic                 icache_flush_out,
  output logic                 fence_busy_out,
  output logic [CNT_WIDTH-1:0] stall_cycles_out
);

  fence_state_e         state_q, state_d;
  logic                 icache_flush_q;
  logic                 fence_busy_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  pipe_ctrl_t ctrl;
  logic       load_use;
  logic       fence_start;
  logic       fsm_holding;

  rv32_load_use_detect u_load_use (
    .decode_valid_i (decode_valid_in),
    .rs1_i          (rs1_in),
    .rs1_read_i     (rs1_read_in),
    .rs2_i          (rs2_in),
    .rs2_read_i     (rs2_read_in),
    .ex_valid_i     (ex_valid_in),
    .ex_mem_read_i  (ex_mem_read_in),
    .ex_rd_i        (ex_rd_in),
    .load_use_o     (load_use)
  );

  assign fence_start = (state_q == StIdle) && mem_fence_in && decode_valid_in;
  assign fsm_holding = (state_q == StDrain) || (state_q == StInval);

  // Priority chain: earlier branches win outright for the whole cycle.
  always_comb begin
    ctrl = CtrlNone;
    if (reset) begin
      ctrl.fetch_flush     = 1'b1;
      ctrl.decode_flush    = 1'b1;
      ctrl.execute_flush   = 1'b1;
      ctrl.mem_flush       = 1'b1;
      ctrl.writeback_flush = 1'b1;
    end else if (trap_in) begin
      ctrl.fetch_flush   = 1'b1;
      ctrl.decode_flush  = 1'b1;
      ctrl.execute_flush = 1'b1;
      ctrl.mem_flush     = 1'b1;
    end else if (mispredict_in) begin
      ctrl.fetch_flush  = 1'b1;
      ctrl.decode_flush = 1'b1;
    end else if (mem_wait_in) begin
      ctrl.fetch_stall   = 1'b1;
      ctrl.decode_stall  = 1'b1;
      ctrl.execute_stall = 1'b1;
      ctrl.mem_flush     = 1'b1;
    end else if (fsm_holding || fence_start || load_use) begin
      // Keep the younger instruction in fetch and feed bubbles behind it.
      ctrl.fetch_stall  = 1'b1;
      ctrl.decode_flush = 1'b1;
    end
  end

  assign fetch_stall_out     = ctrl.fetch_stall;
  assign decode_stall_out    = ctrl.decode_stall;
  assign execute_stall_out   = ctrl.execute_stall;
  assign fetch_flush_out     = ctrl.fetch_flush;
  assign decode_flush_out    = ctrl.decode_flush;
  assign execute_flush_out   = ctrl.execute_flush;
  assign mem_flush_out       = ctrl.mem_flush;
  assign writeback_flush_out = ctrl.writeback_flush;

  always_comb begin
    state_d = state_q;
    if (trap_in || mispredict_in) begin
      // The fence is younger than the redirecting instruction, so it is squashed.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fence_start && !mem_wait_in) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (pipe_drained(ex_valid_in, mem_valid_in, wb_valid_in, mem_wait_in)) begin
            state_d = fence_i_in ? StInval : StRelease;
          end
        end
        StInval: begin
          if (icache_flush_done_in) begin
            state_d = StRelease;
          end
        end
        StRelease: state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  assign stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, ctrl.fetch_stall};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      icache_flush_q <= 1'b0;
      fence_busy_q   <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      icache_flush_q <= (state_d == StInval);
      fence_busy_q   <= (state_d != StIdle);
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign icache_flush_out = icache_flush_q;
  assign fence_busy_out   = fence_busy_q;
  assign stall_cycles_out = stall_cnt_q;

endmodule
